// File: rtl/equiv_sweep_seq_pkg.sv
// Shared types and constants for the exhaustive 4-valued equivalence sweep.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package equiv_sweep_seq_pkg;

    localparam int NGROUPS_DEF = 9;
    localparam int CODE_W      = 16;

    // Per-digit stimulus encoding carried on vec_code
    localparam logic [1:0] D0 = 2'd0;
    localparam logic [1:0] D1 = 2'd1;
    localparam logic [1:0] DX = 2'd2;
    localparam logic [1:0] DZ = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/equiv_sweep_seq_stats.sv
// Failure statistics: saturating fail counter, sticky group mask, first-fail capture.
// Latency: results visible the cycle after the CHECK sample.
// Backpressure: none; clr_i and chk_i are accepted every cycle.
module sweep_stats
    import equiv_sweep_seq_pkg::*;
#(
    parameter int NGROUPS = NGROUPS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic                chk_i,
    input  logic [NGROUPS-1:0]  ok_vec_i,
    input  logic [CODE_W-1:0]   code_i,
    output logic [16:0]         fail_count_o,
    output logic [NGROUPS-1:0]  fail_mask_o,
    output logic [CODE_W-1:0]   first_fail_code_o,
    output logic [NGROUPS-1:0]  first_fail_ok_o,
    output logic                any_fail_o
);

    logic [16:0]        fail_cnt_q, fail_cnt_d;
    logic [NGROUPS-1:0] mask_q, mask_d;
    logic [CODE_W-1:0]  ff_code_q, ff_code_d;
    logic [NGROUPS-1:0] ff_ok_q, ff_ok_d;
    logic               any_q, any_d;
    logic               vec_fail;

    assign vec_fail = chk_i && !(&ok_vec_i);

    always_comb begin
        fail_cnt_d = fail_cnt_q;
        mask_d     = mask_q;
        ff_code_d  = ff_code_q;
        ff_ok_d    = ff_ok_q;
        any_d      = any_q;
        if (clr_i) begin
            fail_cnt_d = '0;
            mask_d     = '0;
            ff_code_d  = '0;
            ff_ok_d    = '0;
            any_d      = 1'b0;
        end else if (vec_fail) begin
            if (fail_cnt_q != {17{1'b1}}) begin
                fail_cnt_d = fail_cnt_q + 17'd1;
            end
            mask_d = mask_q | ~ok_vec_i;
            // Only the first failure of a sweep is kept for debug
            if (!any_q) begin
                ff_code_d = code_i;
                ff_ok_d   = ok_vec_i;
                any_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt_q <= '0;
            mask_q     <= '0;
            ff_code_q  <= '0;
            ff_ok_q    <= '0;
            any_q      <= 1'b0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
            mask_q     <= mask_d;
            ff_code_q  <= ff_code_d;
            ff_ok_q    <= ff_ok_d;
            any_q      <= any_d;
        end
    end

    assign fail_count_o      = fail_cnt_q;
    assign fail_mask_o       = mask_q;
    assign first_fail_code_o = ff_code_q;
    assign first_fail_ok_o   = ff_ok_q;
    assign any_fail_o        = any_q;

endmodule

// File: rtl/equiv_sweep_seq.sv
// Sweeps every 4-valued digit combination, holding each vector SETTLE cycles then checking ok_vec.
// Latency: 4^DIGITS*(SETTLE+1) cycles from the cycle after start to done.
// Backpressure: start ignored while busy; abort ends a running sweep the next cycle.
module equiv_sweep_seq
    import equiv_sweep_seq_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int DIGITS  = 8,
    parameter int NGROUPS = NGROUPS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                stop_on_fail,
    input  logic [NGROUPS-1:0]  ok_vec,
    output logic [CODE_W-1:0]   vec_code,
    output logic                vec_valid,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [16:0]         fail_count,
    output logic [NGROUPS-1:0]  fail_mask,
    output logic [CODE_W-1:0]   first_fail_code,
    output logic [NGROUPS-1:0]  first_fail_ok,
    output logic                any_fail
);

    localparam int             IW       = 2 * DIGITS;
    localparam logic [IW-1:0]  IDX_LAST = {IW{1'b1}};
    localparam logic [7:0]     CNT_LOAD = 8'(SETTLE - 1);

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           sof_q, sof_d;
    logic           aborted_q, aborted_d;
    logic           stats_clr;
    logic           stats_chk;
    logic           vec_fail;

    assign vec_fail = !(&ok_vec);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        sof_d     = sof_q;
        aborted_d = aborted_q;
        stats_clr = 1'b0;
        stats_chk = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    stats_clr = 1'b1;
                    idx_d     = '0;
                    cnt_d     = CNT_LOAD;
                    sof_d     = stop_on_fail;
                    aborted_d = 1'b0;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q == 8'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_CHECK: begin
                // The result is recorded even when abort lands on this cycle
                stats_chk = 1'b1;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (idx_q == IDX_LAST || (sof_q && vec_fail)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            sof_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            sof_q     <= sof_d;
            aborted_q <= aborted_d;
        end
    end

    // Index is zero-extended; the last digit sits in the LSBs and changes fastest
    assign vec_code  = CODE_W'(idx_q);
    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign vec_valid = busy;
    assign done      = (state_q == ST_DONE);
    assign aborted   = aborted_q;

    sweep_stats #(
        .NGROUPS (NGROUPS)
    ) u_stats (
        .clk               (clk),
        .rst_n             (rst_n),
        .clr_i             (stats_clr),
        .chk_i             (stats_chk),
        .ok_vec_i          (ok_vec),
        .code_i            (vec_code),
        .fail_count_o      (fail_count),
        .fail_mask_o       (fail_mask),
        .first_fail_code_o (first_fail_code),
        .first_fail_ok_o   (first_fail_ok),
        .any_fail_o        (any_fail)
    );

endmodule

// File: tb/tb_equiv_sweep_seq.sv
// Directed bench: a small sweep (DIGITS=2, SETTLE=1) driven from a scenario table,
// plus a default-parameter instance for abort/restart and clock-stopped reset sequences.
module tb_equiv_sweep_seq;

    logic clk    = 1'b0;
    logic clk_en = 1'b1;
    logic rst_n  = 1'b0;

    always #5 if (clk_en) clk = ~clk;

    // Small instance
    logic        start_s = 1'b0, abort_s = 1'b0, sof_s = 1'b0;
    logic [8:0]  ok_s;
    logic [15:0] code_s, ffc_s;
    logic        vld_s, busy_s, done_s, abrt_s, any_s;
    logic [16:0] fcnt_s;
    logic [8:0]  fmask_s, ffo_s;
    int          mode_s = 0;

    // Default instance
    logic        start_d = 1'b0, abort_d = 1'b0;
    logic [8:0]  ok_d;
    logic [15:0] code_d, ffc_d;
    logic        vld_d, busy_d, done_d, abrt_d, any_d;
    logic [16:0] fcnt_d;
    logic [8:0]  fmask_d, ffo_d;

    // Environment: which groups mismatch for a given stimulus
    always_comb begin
        ok_s = 9'h1FF;
        if (mode_s == 1 && code_s == 16'h0006) ok_s[3] = 1'b0;
        if (mode_s == 2 && code_s[1:0] == 2'b11) ok_s[0] = 1'b0;
    end

    always_comb begin
        ok_d = 9'h1FF;
        if (code_d[1:0] == 2'b11) ok_d[8] = 1'b0;
    end

    equiv_sweep_seq #(.SETTLE(1), .DIGITS(2), .NGROUPS(9)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s),
        .stop_on_fail(sof_s), .ok_vec(ok_s), .vec_code(code_s), .vec_valid(vld_s),
        .busy(busy_s), .done(done_s), .aborted(abrt_s), .fail_count(fcnt_s),
        .fail_mask(fmask_s), .first_fail_code(ffc_s), .first_fail_ok(ffo_s),
        .any_fail(any_s)
    );

    equiv_sweep_seq u_dflt (
        .clk(clk), .rst_n(rst_n), .start(start_d), .abort(abort_d),
        .stop_on_fail(1'b0), .ok_vec(ok_d), .vec_code(code_d), .vec_valid(vld_d),
        .busy(busy_d), .done(done_d), .aborted(abrt_d), .fail_count(fcnt_d),
        .fail_mask(fmask_d), .first_fail_code(ffc_d), .first_fail_ok(ffo_d),
        .any_fail(any_d)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          mode;
        bit          sof;
        int          exp_len;
        int          exp_cnt;
        logic [8:0]  exp_mask;
        logic [15:0] exp_ffc;
        logic [8:0]  exp_ffo;
        bit          exp_any;
        logic [15:0] exp_last;
    } vec_t;

    vec_t tbl[6];

    // Pulses start on the small instance and follows the sweep until done.
    // seq_ok clears if vec_code ever departs from the 2-cycle index staircase.
    task automatic run_small(input int mode, input bit sof, output int len, output bit seq_ok);
        mode_s  = mode;
        sof_s   = sof;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        sof_s   = ~sof;
        len     = -1;
        seq_ok  = (code_s === 16'h0000) && busy_s && vld_s;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (done_s) begin
                len = k;
                break;
            end
            if (code_s !== 16'(k / 2) || vld_s !== busy_s || !busy_s) seq_ok = 1'b0;
        end
    endtask

    initial begin
        int len;
        bit seq_ok;

        tbl[0] = '{0, 1'b0, 32, 0, 9'h000, 16'h0000, 9'h000, 1'b0, 16'h000F};
        tbl[1] = '{1, 1'b0, 32, 1, 9'h008, 16'h0006, 9'h1F7, 1'b1, 16'h000F};
        tbl[2] = '{1, 1'b1, 14, 1, 9'h008, 16'h0006, 9'h1F7, 1'b1, 16'h0006};
        tbl[3] = '{2, 1'b0, 32, 4, 9'h001, 16'h0003, 9'h1FE, 1'b1, 16'h000F};
        tbl[4] = '{2, 1'b1, 8,  1, 9'h001, 16'h0003, 9'h1FE, 1'b1, 16'h0003};
        tbl[5] = '{0, 1'b1, 32, 0, 9'h000, 16'h0000, 9'h000, 1'b0, 16'h000F};

        // Reset state
        #1;
        chk("rst_busy",  {31'd0, busy_s}, 32'd0);
        chk("rst_done",  {31'd0, done_s}, 32'd0);
        chk("rst_code",  {16'd0, code_s}, 32'd0);
        chk("rst_fcnt",  {15'd0, fcnt_s}, 32'd0);
        chk("rst_dflt",  {30'd0, busy_d, done_d}, 32'd0);
        #12;
        rst_n = 1'b1;
        tick();

        // abort while idle is ignored
        abort_s = 1'b1;
        tick();
        abort_s = 1'b0;
        tick();
        chk("idle_abort", {30'd0, done_s, abrt_s}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_small(tbl[i].mode, tbl[i].sof, len, seq_ok);
            chk($sformatf("t%0d_len", i),   32'(len), 32'(tbl[i].exp_len));
            chk($sformatf("t%0d_seq", i),   {31'd0, seq_ok}, 32'd1);
            chk($sformatf("t%0d_cnt", i),   {15'd0, fcnt_s}, 32'(tbl[i].exp_cnt));
            chk($sformatf("t%0d_mask", i),  {23'd0, fmask_s}, {23'd0, tbl[i].exp_mask});
            chk($sformatf("t%0d_ffc", i),   {16'd0, ffc_s}, {16'd0, tbl[i].exp_ffc});
            chk($sformatf("t%0d_ffo", i),   {23'd0, ffo_s}, {23'd0, tbl[i].exp_ffo});
            chk($sformatf("t%0d_any", i),   {31'd0, any_s}, {31'd0, tbl[i].exp_any});
            chk($sformatf("t%0d_last", i),  {16'd0, code_s}, {16'd0, tbl[i].exp_last});
            chk($sformatf("t%0d_flags", i), {29'd0, busy_s, vld_s, abrt_s}, 32'd0);
            tick();
            chk($sformatf("t%0d_hold", i),  {15'd0, done_s, code_s}, {15'd0, 1'b1, tbl[i].exp_last});
        end

        // Default parameters: abort lands on the CHECK of vector 19 (cycle 100 of the sweep)
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        for (int k = 1; k < 100; k++) tick();
        chk("d_busy_pre", {31'd0, busy_d}, 32'd1);
        abort_d = 1'b1;
        tick();
        abort_d = 1'b0;
        chk("d_abort_flags", {29'd0, done_d, abrt_d, busy_d}, 32'b110);
        chk("d_abort_code",  {16'd0, code_d}, 32'h0013);
        chk("d_abort_cnt",   {15'd0, fcnt_d}, 32'd5);
        chk("d_abort_mask",  {23'd0, fmask_d}, 32'h100);
        chk("d_abort_ff",    {ffc_d, 7'd0, ffo_d}, {16'h0003, 7'd0, 9'h0FF});
        abort_d = 1'b1;
        tick();
        abort_d = 1'b0;
        chk("d_done_abort", {30'd0, done_d, abrt_d}, 32'b11);
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        chk("d_restart_flags", {28'd0, done_d, abrt_d, busy_d, any_d}, 32'b0010);
        chk("d_restart_stats", {15'd0, fcnt_d}, 32'd0);
        chk("d_restart_ff",    {ffc_d, 7'd0, ffo_d | fmask_d}, 32'd0);
        abort_d = 1'b1;
        tick();
        abort_d = 1'b0;
        chk("d_settle_abort", {29'd0, done_d, abrt_d, busy_d}, 32'b110);

        // start while busy must not disturb the index
        mode_s  = 2;
        sof_s   = 1'b0;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        chk("busy_start_code", {16'd0, code_s}, 32'h0003);
        for (int k = 7; k <= 12; k++) tick();
        chk("mid_code", {16'd0, code_s}, 32'h0006);
        chk("mid_fcnt", {15'd0, fcnt_s}, 32'd1);

        // Reset with the clock stopped
        clk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_flags", {27'd0, busy_s, vld_s, done_s, abrt_s, any_s}, 32'd0);
        chk("arst_code",  {16'd0, code_s}, 32'd0);
        chk("arst_stats", {15'd0, fcnt_s}, 32'd0);
        chk("arst_ff",    {ffc_s, 7'd0, ffo_s | fmask_s}, 32'd0);
        #3;
        rst_n  = 1'b1;
        #2;
        clk_en = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("post_rst", {29'd0, done_s, busy_s, done_d}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
